// File: rtl/cpu_types_pkg.sv
// ---- cpu_types_pkg : shared CPU phase type, interrupt sources, IF/IE map (rev 1.0) ----
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_phase_t;

  typedef enum logic [2:0] {
    VBLANK = 3'd0,
    STAT   = 3'd1,
    TIMER  = 3'd2,
    SERIAL = 3'd3,
    JOYPAD = 3'd4
  } irq_src_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } ic_state_t;

  localparam int unsigned NUM_IRQ     = 5;
  localparam logic [7:0]  VECTOR_BASE = 8'h40;
  localparam logic [15:0] ADDR_IF     = 16'hFF0F;
  localparam logic [15:0] ADDR_IE     = 16'hFFFF;

  function automatic logic [7:0] irq_vector(input logic [2:0] idx);
    return VECTOR_BASE + {2'b00, idx, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// ---- interrupt_controller_if : CPU memory-cycle bus into the IF/IE registers (rev 1.0) ----
`default_nettype none

interface interrupt_controller_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_wdata, bus_rd, bus_wr,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_rd, bus_wr,
    output bus_rdata, bus_hit
  );
endinterface

`default_nettype wire

// File: rtl/irq_priority_encoder.sv
// ---- irq_priority_encoder : lowest-index-first encoder over the pending sources (rev 1.0) ----
`default_nettype none

module irq_priority_encoder
  import cpu_types_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [2:0]         o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = 3'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ---- interrupt_controller : IF/IE registers, dispatch FSM, vector latch (rev 1.0) ----
// Optional macro IRQ_EDGE_DETECT_EN: irq_req treated as levels with 0->1 edge detection.
`default_nettype none

module interrupt_controller
  import cpu_types_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  t_phase_t               t_phase,
  interrupt_controller_if.slave  bus,
  input  logic [NUM_IRQ-1:0]     irq_req,
  input  logic                   ime,
  output logic                   int_pending,
  output logic                   int_take,
  input  logic                   int_ack,
  input  logic                   int_done,
  output logic [7:0]             int_vector
);

  ic_state_t          r_state, w_state_nx;
  logic [NUM_IRQ-1:0] r_if, w_if_nx, w_req_evt;
  logic [7:0]         r_ie, w_ie_nx, r_vec, r_rdata;
  logic               w_hit, w_if_wr, w_ie_wr, w_ack_take, w_rd_hit;
  logic               w_enc_valid;
  logic [2:0]         w_enc_idx;

  assign w_hit      = (bus.bus_addr == ADDR_IF) || (bus.bus_addr == ADDR_IE);
  assign w_if_wr    = bus.bus_wr && (t_phase == T4) && (bus.bus_addr == ADDR_IF);
  assign w_ie_wr    = bus.bus_wr && (t_phase == T4) && (bus.bus_addr == ADDR_IE);
  assign w_rd_hit   = bus.bus_rd && (t_phase == T3) && w_hit;
  assign w_ack_take = int_ack && (r_state == IDLE);
  assign w_ie_nx    = w_ie_wr ? bus.bus_wdata : r_ie;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] r_irq_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq_prev <= '0;
    else       r_irq_prev <= irq_req;
  end

  assign w_req_evt = irq_req & ~r_irq_prev;
`else
  assign w_req_evt = irq_req;
`endif

  // Ack arbitrates against the IE value being committed this edge, so an
  // overwrite of IE coinciding with the ack cancels the dispatch.
  irq_priority_encoder u_prio (
    .i_req   (w_ie_nx[NUM_IRQ-1:0] & r_if),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  always_comb begin
    w_if_nx = w_if_wr ? bus.bus_wdata[NUM_IRQ-1:0] : r_if;
    if (w_ack_take && w_enc_valid) w_if_nx = w_if_nx & ~(5'b00001 << w_enc_idx);
    w_if_nx = w_if_nx | w_req_evt;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:     if (int_ack)  w_state_nx = DISPATCH;
      DISPATCH: if (int_done) w_state_nx = IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if    <= '0;
      r_ie    <= 8'h00;
      r_vec   <= 8'h00;
      r_rdata <= 8'hFF;
    end else begin
      r_if <= w_if_nx;
      r_ie <= w_ie_nx;
      if (w_ack_take) r_vec <= w_enc_valid ? irq_vector(w_enc_idx) : 8'h00;
      if (w_rd_hit)   r_rdata <= (bus.bus_addr == ADDR_IF) ? {3'b111, r_if} : r_ie;
    end
  end

  assign int_pending   = |(r_ie[NUM_IRQ-1:0] & r_if);
  assign int_take      = int_pending && ime && (r_state == IDLE);
  assign int_vector    = r_vec;
  assign bus.bus_rdata = r_rdata;
  assign bus.bus_hit   = w_hit;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ---- tb_interrupt_controller : vector table, corner sequences and random run vs reference model (rev 1.0) ----
`default_nettype none

module tb_interrupt_controller;
  import cpu_types_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  t_phase_t   t_phase;
  logic [4:0] irq_req;
  logic       ime, int_ack, int_done;
  logic       int_pending, int_take;
  logic [7:0] int_vector;

  interrupt_controller_if bus_if ();

  interrupt_controller dut (
    .clk         (clk),
    .reset       (reset),
    .t_phase     (t_phase),
    .bus         (bus_if),
    .irq_req     (irq_req),
    .ime         (ime),
    .int_pending (int_pending),
    .int_take    (int_take),
    .int_ack     (int_ack),
    .int_done    (int_done),
    .int_vector  (int_vector)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: architectural register contents, dispatch flag, latched outputs.
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie, m_vec, m_rd;
  bit         m_disp;
  logic       s_pend, s_take;

  typedef struct {
    t_phase_t    ph;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [4:0]  ctl;   // {rd, wr, ime, ack, done}
    logic [4:0]  irq;
    logic [1:0]  pt;    // expected {int_pending, int_take} before the edge
    logic [7:0]  vec;   // expected int_vector after the edge
    logic [7:0]  rdata; // expected bus_rdata after the edge
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int lowest(input logic [4:0] v);
    for (int n = 0; n < 5; n++) if (v[n]) return n;
    return -1;
  endfunction

  task automatic model_reset();
    m_if = 5'h00; m_ie = 8'h00; m_vec = 8'h00; m_rd = 8'hFF; m_disp = 1'b0; m_prev = 5'h00;
  endtask

  task automatic drive(input t_phase_t ph, input logic [15:0] a, input logic [7:0] wd,
                       input logic [4:0] ctl, input logic [4:0] irq);
    t_phase          = ph;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = wd;
    bus_if.bus_rd    = ctl[4];
    bus_if.bus_wr    = ctl[3];
    ime              = ctl[2];
    int_ack          = ctl[1];
    int_done         = ctl[0];
    irq_req          = irq;
  endtask

  // One clock: check combinational outputs at negedge, advance model, check latched outputs.
  task automatic tick();
    logic       hit, pend;
    logic [4:0] evt, ifn;
    logic [7:0] ien, rdn, vecn;
    bit         dispn;
    int         n;
    @(negedge clk);
    hit  = (bus_if.bus_addr == 16'hFF0F) || (bus_if.bus_addr == 16'hFFFF);
    pend = |(m_ie[4:0] & m_if);
    s_pend = int_pending;
    s_take = int_take;
    chk("bus_hit", 16'(bus_if.bus_hit), 16'(hit));
    chk("int_pending", 16'(int_pending), 16'(pend));
    chk("int_take", 16'(int_take), 16'(pend && ime && !m_disp));
`ifdef IRQ_EDGE_DETECT_EN
    evt = irq_req & ~m_prev;
`else
    evt = irq_req;
`endif
    ien  = (bus_if.bus_wr && t_phase == T4 && bus_if.bus_addr == 16'hFFFF) ? bus_if.bus_wdata : m_ie;
    ifn  = (bus_if.bus_wr && t_phase == T4 && bus_if.bus_addr == 16'hFF0F) ? bus_if.bus_wdata[4:0] : m_if;
    rdn  = m_rd;
    if (t_phase == T3 && bus_if.bus_rd && hit)
      rdn = (bus_if.bus_addr == 16'hFF0F) ? {3'b111, m_if} : m_ie;
    vecn  = m_vec;
    dispn = m_disp;
    if (!m_disp && int_ack) begin
      n = lowest(ien[4:0] & m_if);
      if (n >= 0) begin
        vecn   = 8'(64 + 8 * n);
        ifn[n] = 1'b0;
      end else begin
        vecn = 8'h00;
      end
      dispn = 1'b1;
    end else if (m_disp && int_done) begin
      dispn = 1'b0;
    end
    ifn = ifn | evt;
    @(posedge clk);
    #1;
    m_if = ifn; m_ie = ien; m_rd = rdn; m_vec = vecn; m_disp = dispn; m_prev = irq_req;
    chk("int_vector", 16'(int_vector), 16'(m_vec));
    chk("bus_rdata", 16'(bus_if.bus_rdata), 16'(m_rd));
  endtask

  task automatic idle_in();
    drive(T1, 16'h0000, 8'h00, 5'b00000, 5'h00);
  endtask

  initial begin
    logic [7:0] exp_hold;
    tbl[0]  = '{T4, 16'hFFFF, 8'h05, 5'b01000, 5'h00, 2'b00, 8'h00, 8'hFF};
    tbl[1]  = '{T1, 16'h0000, 8'h00, 5'b00000, 5'h04, 2'b00, 8'h00, 8'hFF};
    tbl[2]  = '{T2, 16'h0000, 8'h00, 5'b00100, 5'h00, 2'b11, 8'h00, 8'hFF};
    tbl[3]  = '{T1, 16'h0000, 8'h00, 5'b00110, 5'h00, 2'b11, 8'h50, 8'hFF};
    tbl[4]  = '{T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h50, 8'hE0};
    tbl[5]  = '{T3, 16'hFFFF, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h50, 8'h05};
    tbl[6]  = '{T1, 16'h0000, 8'h00, 5'b00001, 5'h00, 2'b00, 8'h50, 8'h05};
    tbl[7]  = '{T4, 16'hFF0F, 8'h00, 5'b01000, 5'h02, 2'b00, 8'h50, 8'h05};
    tbl[8]  = '{T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h50, 8'hE2};
    tbl[9]  = '{T2, 16'hFF0F, 8'h00, 5'b01000, 5'h00, 2'b00, 8'h50, 8'hE2};
    tbl[10] = '{T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h50, 8'hE2};
    tbl[11] = '{T4, 16'hFFFF, 8'h1F, 5'b01000, 5'h00, 2'b00, 8'h50, 8'hE2};
    tbl[12] = '{T4, 16'hFF0F, 8'h00, 5'b01000, 5'h00, 2'b10, 8'h50, 8'hE2};
    tbl[13] = '{T1, 16'h0000, 8'h00, 5'b00000, 5'h11, 2'b00, 8'h50, 8'hE2};
    tbl[14] = '{T1, 16'h0000, 8'h00, 5'b00110, 5'h00, 2'b11, 8'h40, 8'hE2};
    tbl[15] = '{T3, 16'hFF0F, 8'h00, 5'b10100, 5'h00, 2'b10, 8'h40, 8'hF0};
    tbl[16] = '{T1, 16'h0000, 8'h00, 5'b00101, 5'h00, 2'b10, 8'h40, 8'hF0};
    tbl[17] = '{T1, 16'h0000, 8'h00, 5'b00110, 5'h00, 2'b11, 8'h60, 8'hF0};
    tbl[18] = '{T1, 16'h0000, 8'h00, 5'b00001, 5'h00, 2'b00, 8'h60, 8'hF0};
    tbl[19] = '{T4, 16'hFFFF, 8'h04, 5'b01000, 5'h00, 2'b00, 8'h60, 8'hF0};
    tbl[20] = '{T1, 16'h0000, 8'h00, 5'b00000, 5'h04, 2'b00, 8'h60, 8'hF0};
    tbl[21] = '{T4, 16'hFFFF, 8'h00, 5'b01110, 5'h00, 2'b11, 8'h00, 8'hF0};
    tbl[22] = '{T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h00, 8'hE4};
    tbl[23] = '{T1, 16'h0000, 8'h00, 5'b00001, 5'h00, 2'b00, 8'h00, 8'hE4};
    tbl[24] = '{T3, 16'hFFFF, 8'h00, 5'b10000, 5'h00, 2'b00, 8'h00, 8'h00};

    // Power-on reset
    reset = 1'b1;
    idle_in();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset int_vector", 16'(int_vector), 16'h0000);
    chk("reset bus_rdata", 16'(bus_if.bus_rdata), 16'h00FF);
    chk("reset int_pending", 16'(int_pending), 16'h0000);
    chk("reset int_take", 16'(int_take), 16'h0000);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].ph, tbl[i].addr, tbl[i].wd, tbl[i].ctl, tbl[i].irq);
      tick();
      chk($sformatf("tbl%0d pend", i), 16'(s_pend), 16'(tbl[i].pt[1]));
      chk($sformatf("tbl%0d take", i), 16'(s_take), 16'(tbl[i].pt[0]));
      chk($sformatf("tbl%0d vector", i), 16'(int_vector), 16'(tbl[i].vec));
      chk($sformatf("tbl%0d rdata", i), 16'(bus_if.bus_rdata), 16'(tbl[i].rdata));
    end

    // Level held on VBlank, IF cleared mid-hold
    drive(T4, 16'hFFFF, 8'h01, 5'b01000, 5'h00); tick();
    drive(T4, 16'hFF0F, 8'h00, 5'b01000, 5'h00); tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 5) drive(T4, 16'hFF0F, 8'h00, 5'b01000, 5'h01);
      else        drive(T1, 16'h0000, 8'h00, 5'b00000, 5'h01);
      tick();
    end
    drive(T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00); tick();
`ifdef IRQ_EDGE_DETECT_EN
    exp_hold = 8'hE0;
`else
    exp_hold = 8'hE1;
`endif
    chk("held level IF", 16'(bus_if.bus_rdata), 16'(exp_hold));

    // Reset in the middle of a dispatch
    drive(T4, 16'hFFFF, 8'hFF, 5'b01000, 5'h00); tick();
    drive(T1, 16'h0000, 8'h00, 5'b00000, 5'h08); tick();
    drive(T1, 16'h0000, 8'h00, 5'b00110, 5'h00); tick();
    idle_in();
    reset = 1'b1;
    #2;
    model_reset();
    chk("async reset int_vector", 16'(int_vector), 16'h0000);
    chk("async reset bus_rdata", 16'(bus_if.bus_rdata), 16'h00FF);
    chk("async reset int_pending", 16'(int_pending), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    drive(T3, 16'hFF0F, 8'h00, 5'b10000, 5'h00); tick();
    chk("post reset IF", 16'(bus_if.bus_rdata), 16'h00E0);
    drive(T3, 16'hFFFF, 8'h00, 5'b10000, 5'h00); tick();
    chk("post reset IE", 16'(bus_if.bus_rdata), 16'h0000);
    drive(T4, 16'hFFFF, 8'h01, 5'b01000, 5'h00); tick();
    drive(T1, 16'h0000, 8'h00, 5'b00100, 5'h01); tick();
    drive(T1, 16'h0000, 8'h00, 5'b00100, 5'h00); tick();
    chk("post reset take", 16'(s_take), 16'h0001);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [15:0] a;
      logic [4:0]  ctl;
      logic [4:0]  irq;
      case ($urandom_range(0, 3))
        0:       a = 16'hFF0F;
        1:       a = 16'hFFFF;
        2:       a = 16'hFF0E;
        default: a = 16'($urandom);
      endcase
      ctl    = 5'($urandom);
      ctl[1] = ($urandom_range(0, 3) == 0);
      ctl[0] = ($urandom_range(0, 3) == 0);
      irq    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
      drive(t_phase_t'(2'($urandom_range(0, 3))), a, 8'($urandom), ctl, irq);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
